// File: rtl/i2c_target_regfile.sv
// I2C target with a 16 x 8-bit register file.
// Register 0 is read-only and returns DEV_ID; registers 1..15 are writable from the bus.
// A write is: START, address+W, pointer byte, data bytes..., STOP.
// A read is: START, address+R, data bytes..., master NACK, STOP (usually after a pointer write).
// Optional feature: define I2C_TARGET_AUTOINC_EN to advance the pointer after every data byte.
module i2c_target_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h53,
   parameter logic [7:0] DEV_ID   = 8'hE5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       busy,
   output logic       wr_strobe,
   output logic [3:0] wr_index,
   output logic [7:0] wr_data,
   input  logic [3:0] rd_index,
   output logic [7:0] rd_data
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_MACK
   } state_t;

   // Bus synchronizers and edge-detect history
   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_prev_q;
   logic       sda_prev_q;
   logic [1:0] warm_q;

   // Protocol state
   state_t     state_q;
   logic [3:0] bit_cnt_q;
   logic [7:0] shift_q;
   logic       rw_q;
   logic       mack_q;
   logic [3:0] ptr_q;
   logic       sda_oe_q;
   logic       busy_q;
   logic       wr_strobe_q;
   logic [3:0] wr_index_q;
   logic [7:0] wr_data_q;
   logic [7:0] rd_data_q;

   // Register file; entry 0 is never written, reads of index 0 return DEV_ID
   logic [7:0] regs_q [16];

   logic       scl_h;
   logic       sda_h;
   logic       bus_ok;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [3:0] ptr_step_d;
   logic [7:0] rd_byte_d;
   logic [7:0] wbyte_d;

   function automatic logic [7:0] reg_read(input logic [3:0] idx);
      return (idx == 4'd0) ? DEV_ID : regs_q[idx];
   endfunction

   // Two-flop synchronizers, edge history and a short warm-up so that the
   // reset value of the history flops cannot fake a START/STOP edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         warm_q     <= 2'd0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_in};
         sda_sync_q <= {sda_sync_q[0], sda_in};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
         if (warm_q != 2'd3) begin
            warm_q <= warm_q + 2'd1;
         end
      end
   end

   assign scl_h     = scl_sync_q[1];
   assign sda_h     = sda_sync_q[1];
   assign bus_ok    = (warm_q == 2'd3);
   assign scl_rise  = bus_ok &  scl_h & ~scl_prev_q;
   assign scl_fall  = bus_ok & ~scl_h &  scl_prev_q;
   assign start_det = bus_ok & scl_h & scl_prev_q &  sda_prev_q & ~sda_h;
   assign stop_det  = bus_ok & scl_h & scl_prev_q & ~sda_prev_q &  sda_h;

`ifdef I2C_TARGET_AUTOINC_EN
   assign ptr_step_d = ptr_q + 4'd1;
`else
   assign ptr_step_d = ptr_q;
`endif

   assign rd_byte_d = reg_read(ptr_q);
   assign wbyte_d   = {shift_q[6:0], sda_h};

   // Protocol FSM: bits shift in on SCL rise, SDA drive changes on SCL fall
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         rw_q        <= 1'b0;
         mack_q      <= 1'b0;
         ptr_q       <= 4'd0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_index_q  <= 4'd0;
         wr_data_q   <= 8'h00;
      end else begin
         wr_strobe_q <= 1'b0;
         if (stop_det) begin
            state_q   <= IDLE;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            bit_cnt_q <= 4'd0;
         end else if (start_det) begin
            state_q   <= ADDR;
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= 4'd0;
         end else begin
            case (state_q)
               IDLE: begin
                  sda_oe_q <= 1'b0;
               end
               ADDR, PTR, WDATA: begin
                  if (scl_rise && (bit_cnt_q < 4'd8)) begin
                     shift_q   <= wbyte_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if ((state_q == WDATA) && (bit_cnt_q == 4'd7)) begin
                        if (ptr_q != 4'd0) begin
                           wr_strobe_q <= 1'b1;
                           wr_index_q  <= ptr_q;
                           wr_data_q   <= wbyte_d;
                        end
                        ptr_q <= ptr_step_d;
                     end
                  end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                     bit_cnt_q <= 4'd0;
                     if (state_q == ADDR) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                           sda_oe_q <= 1'b1;
                           busy_q   <= 1'b1;
                           rw_q     <= shift_q[0];
                           state_q  <= ADDR_ACK;
                        end else begin
                           state_q  <= IDLE;
                        end
                     end else if (state_q == PTR) begin
                        ptr_q    <= shift_q[3:0];
                        sda_oe_q <= 1'b1;
                        state_q  <= PTR_ACK;
                     end else begin
                        sda_oe_q <= 1'b1;
                        state_q  <= WDATA_ACK;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt_q <= 4'd0;
                     if (rw_q) begin
                        shift_q  <= rd_byte_d;
                        sda_oe_q <= ~rd_byte_d[7];
                        state_q  <= RDATA;
                     end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= PTR;
                     end
                  end
               end
               PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     sda_oe_q  <= 1'b0;
                     bit_cnt_q <= 4'd0;
                     state_q   <= WDATA;
                  end
               end
               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        ptr_q     <= ptr_step_d;
                        state_q   <= RDATA_MACK;
                     end else begin
                        shift_q  <= {shift_q[6:0], 1'b0};
                        sda_oe_q <= ~shift_q[6];
                     end
                  end
               end
               RDATA_MACK: begin
                  if (scl_rise) begin
                     mack_q <= ~sda_h;
                  end else if (scl_fall) begin
                     bit_cnt_q <= 4'd0;
                     if (mack_q) begin
                        shift_q  <= rd_byte_d;
                        sda_oe_q <= ~rd_byte_d[7];
                        state_q  <= RDATA;
                     end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= IDLE;
                     end
                  end
               end
               default: begin
                  sda_oe_q <= 1'b0;
                  state_q  <= IDLE;
               end
            endcase
         end
      end
   end

   // Register file update, one clk behind wr_strobe so a same-clk local read sees the old value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (wr_strobe_q && (wr_index_q != 4'd0)) begin
         regs_q[wr_index_q] <= wr_data_q;
      end
   end

   // Local registered readback port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= 8'h00;
      end else begin
         rd_data_q <= reg_read(rd_index);
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_index  = wr_index_q;
   assign wr_data   = wr_data_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed testbench for i2c_target_regfile: a bit-banged I2C master with an
// open-drain SDA model, wr_strobe monitor, and per-scenario checking tasks.
module tb_i2c_target_regfile;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       scl_m;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic       busy;
   logic       wr_strobe;
   logic [3:0] wr_index;
   logic [7:0] wr_data;
   logic [3:0] rd_index;
   logic [7:0] rd_data;

   int         checks   = 0;
   int         failures = 0;
   int         wr_count = 0;
   logic [3:0] last_idx = 4'd0;
   logic [7:0] last_data = 8'h00;
   logic       busy_seen = 1'b0;
   logic       collide_pend = 1'b0;
   logic [7:0] collide_rd = 8'hFF;

   always #5 clk = ~clk;

   assign sda_line = sda_m & ~sda_oe;

   i2c_target_regfile dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .wr_strobe (wr_strobe),
      .wr_index  (wr_index),
      .wr_data   (wr_data),
      .rd_index  (rd_index),
      .rd_data   (rd_data)
   );

   // Monitor: count write strobes, note busy, capture readback right after a colliding write
   always @(negedge clk) begin
      if (collide_pend) begin
         collide_rd   = rd_data;
         collide_pend = 1'b0;
      end
      if (wr_strobe) begin
         wr_count++;
         last_idx  = wr_index;
         last_data = wr_data;
         if (wr_index == rd_index) collide_pend = 1'b1;
      end
      if (busy) busy_seen = 1'b1;
   end

   // Quarter SCL period = 5 clk (SCL = clk/20)
   task automatic wait_q();
      repeat (5) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b = sda_line; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] v, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(output logic [7:0] v, input logic ack_it);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      write_bit(~ack_it);
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      scl_m    = 1'b1;
      sda_m    = 1'b1;
      rd_index = 4'd0;
      repeat (3) @(negedge clk);
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
      checks++; if ({wr_index, wr_data} !== 12'h000) begin failures++; $display("FAIL reset_wr_bus: got idx=%h data=%h expected 0/00", wr_index, wr_data); end
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (rd_data !== 8'hE5) begin failures++; $display("FAIL rd_reg0: got %h expected e5", rd_data); end
      rd_index = 4'd5;
      @(negedge clk);
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rd_reg5_reset: got %h expected 00", rd_data); end
      repeat (4) @(negedge clk);
      $display("txn reset done");
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      int   wc0;
      wc0 = wr_count;
      busy_seen = 1'b0;
      i2c_start();
      write_byte(8'hA6, a0);
      write_byte(8'h05, a1);
      write_byte(8'h3C, a2);
      i2c_stop();
      wait_q();
      $display("txn write idx=5 data=3c acks=%b%b%b", a0, a1, a2);
      checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL wr_acks: got %b%b%b expected 111", a0, a1, a2); end
      checks++; if (wr_count - wc0 !== 1) begin failures++; $display("FAIL wr_strobe_count: got %0d expected 1", wr_count - wc0); end
      checks++; if (last_idx !== 4'd5) begin failures++; $display("FAIL wr_index: got %h expected 5", last_idx); end
      checks++; if (last_data !== 8'h3C) begin failures++; $display("FAIL wr_data: got %h expected 3c", last_data); end
      checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL wr_busy_seen: got %b expected 1", busy_seen); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop: got %b expected 0", busy); end
      rd_index = 4'd5;
      @(negedge clk);
      checks++; if (rd_data !== 8'h3C) begin failures++; $display("FAIL wr_readback: got %h expected 3c", rd_data); end
   endtask

   task automatic test_read_id();
      logic       a0, a1, a2;
      logic [7:0] v;
      i2c_start();
      write_byte(8'hA6, a0);
      write_byte(8'h00, a1);
      i2c_start();
      write_byte(8'hA7, a2);
      read_byte(v, 1'b0);
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rid_sda_oe_after_nack: got %b expected 0", sda_oe); end
      i2c_stop();
      wait_q();
      $display("txn read reg0 data=%h acks=%b%b%b", v, a0, a1, a2);
      checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL rid_acks: got %b%b%b expected 111", a0, a1, a2); end
      checks++; if (v !== 8'hE5) begin failures++; $display("FAIL rid_data: got %h expected e5", v); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rid_busy: got %b expected 0", busy); end
   endtask

   task automatic test_write_reg0();
      logic a0, a1, a2;
      int   wc0;
      wc0 = wr_count;
      i2c_start();
      write_byte(8'hA6, a0);
      write_byte(8'h00, a1);
      write_byte(8'h77, a2);
      i2c_stop();
      wait_q();
      $display("txn write reg0 data=77 acks=%b%b%b", a0, a1, a2);
      checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL w0_acks: got %b%b%b expected 111", a0, a1, a2); end
      checks++; if (wr_count - wc0 !== 0) begin failures++; $display("FAIL w0_strobe_count: got %0d expected 0", wr_count - wc0); end
      rd_index = 4'd0;
      @(negedge clk);
      checks++; if (rd_data !== 8'hE5) begin failures++; $display("FAIL w0_readback: got %h expected e5", rd_data); end
   endtask

   task automatic test_addr_nack();
      logic a0;
      int   wc0;
      wc0 = wr_count;
      busy_seen = 1'b0;
      i2c_start();
      write_byte(8'hA8, a0);
      i2c_stop();
      wait_q();
      $display("txn addr 0xa8 ack=%b", a0);
      checks++; if (a0 !== 1'b0) begin failures++; $display("FAIL nack_ack: got %b expected 0", a0); end
      checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL nack_busy: got %b expected 0", busy_seen); end
      checks++; if (wr_count - wc0 !== 0) begin failures++; $display("FAIL nack_strobe: got %0d expected 0", wr_count - wc0); end
   endtask

   task automatic test_multi_byte();
      logic       a0, a1, a2, a3, a4, a5, a6, a7;
      logic [7:0] v0, v1;
      int         wc0;
      int         exp_cnt;
      logic [7:0] exp_last, exp_r15, exp_v0, exp_v1;
`ifdef I2C_TARGET_AUTOINC_EN
      exp_cnt = 1; exp_last = 8'h11; exp_r15 = 8'h11; exp_v0 = 8'h99; exp_v1 = 8'h00;
`else
      exp_cnt = 2; exp_last = 8'h22; exp_r15 = 8'h22; exp_v0 = 8'h22; exp_v1 = 8'h22;
`endif
      i2c_start();
      write_byte(8'hA6, a0);
      write_byte(8'h01, a1);
      write_byte(8'h99, a2);
      i2c_stop();
      wait_q();
      $display("txn write idx=1 data=99 acks=%b%b%b", a0, a1, a2);
      wc0 = wr_count;
      i2c_start();
      write_byte(8'hA6, a3);
      write_byte(8'h0F, a4);
      write_byte(8'h11, a5);
      write_byte(8'h22, a6);
      i2c_stop();
      wait_q();
      $display("txn write idx=15 data=11,22 acks=%b%b%b%b", a3, a4, a5, a6);
      checks++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'h7F) begin failures++; $display("FAIL mb_acks: got %b expected 1111111", {a0, a1, a2, a3, a4, a5, a6}); end
      checks++; if (wr_count - wc0 !== exp_cnt) begin failures++; $display("FAIL mb_strobe_count: got %0d expected %0d", wr_count - wc0, exp_cnt); end
      checks++; if (last_data !== exp_last || last_idx !== 4'hF) begin failures++; $display("FAIL mb_last_write: got %h/%h expected f/%h", last_idx, last_data, exp_last); end
      rd_index = 4'd15;
      @(negedge clk);
      checks++; if (rd_data !== exp_r15) begin failures++; $display("FAIL mb_reg15: got %h expected %h", rd_data, exp_r15); end
      rd_index = 4'd0;
      @(negedge clk);
      checks++; if (rd_data !== 8'hE5) begin failures++; $display("FAIL mb_reg0: got %h expected e5", rd_data); end
      i2c_start();
      write_byte(8'hA7, a7);
      read_byte(v0, 1'b1);
      read_byte(v1, 1'b0);
      i2c_stop();
      wait_q();
      $display("txn read 2 bytes data=%h,%h ack=%b", v0, v1, a7);
      checks++; if (a7 !== 1'b1) begin failures++; $display("FAIL mb_rd_ack: got %b expected 1", a7); end
      checks++; if (v0 !== exp_v0) begin failures++; $display("FAIL mb_rd_byte0: got %h expected %h", v0, exp_v0); end
      checks++; if (v1 !== exp_v1) begin failures++; $display("FAIL mb_rd_byte1: got %h expected %h", v1, exp_v1); end
   endtask

   task automatic test_stop_mid_wdata();
      logic a0, a1, a2;
      int   wc0;
      wc0 = wr_count;
      i2c_start();
      write_byte(8'hA6, a0);
      write_byte(8'h03, a1);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      i2c_stop();
      wait_q();
      $display("txn stop mid-wdata acks=%b%b", a0, a1);
      checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL smw_acks: got %b%b expected 11", a0, a1); end
      checks++; if (wr_count - wc0 !== 0) begin failures++; $display("FAIL smw_strobe: got %0d expected 0", wr_count - wc0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL smw_busy: got %b expected 0", busy); end
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL smw_sda_oe: got %b expected 0", sda_oe); end
      // Without a new START the target stays idle and must not ACK anything
      scl_m = 1'b0; wait_q();
      write_byte(8'hA6, a2);
      i2c_stop();
      wait_q();
      $display("txn bits without start ack=%b", a2);
      checks++; if (a2 !== 1'b0) begin failures++; $display("FAIL smw_idle_ack: got %b expected 0", a2); end
   endtask

   task automatic test_reset_mid_read();
      logic       a0, a1, a2, a3, a4, a5, b;
      logic [2:0] bits;
      int         wc0;
      i2c_start();
      write_byte(8'hA6, a0);
      write_byte(8'h07, a1);
      i2c_start();
      write_byte(8'hA7, a2);
      for (int i = 0; i < 3; i++) begin
         read_bit(b);
         bits[i] = b;
      end
      checks++; if ({a0, a1, a2, bits} !== 6'b111000) begin failures++; $display("FAIL rmr_pre: got acks=%b%b%b bits=%b expected 111/000", a0, a1, a2, bits); end
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rmr_driving: got %b expected 1", sda_oe); end
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rmr_sda_release: got %b expected 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmr_busy: got %b expected 0", busy); end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      scl_m = 1'b0; wait_q();
      read_bit(bits[0]);
      read_bit(bits[1]);
      checks++; if (bits[1:0] !== 2'b11) begin failures++; $display("FAIL rmr_ignore_bus: got %b expected 11", bits[1:0]); end
      rd_index = 4'd5;
      @(negedge clk);
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rmr_regs_cleared: got %h expected 00", rd_data); end
      $display("txn reset during read bit 3");
      rd_index = 4'd9;
      wc0 = wr_count;
      i2c_start();
      write_byte(8'hA6, a3);
      write_byte(8'h09, a4);
      write_byte(8'h5A, a5);
      i2c_stop();
      wait_q();
      $display("txn write idx=9 data=5a acks=%b%b%b", a3, a4, a5);
      checks++; if ({a3, a4, a5} !== 3'b111) begin failures++; $display("FAIL rmr_wr_acks: got %b%b%b expected 111", a3, a4, a5); end
      checks++; if (wr_count - wc0 !== 1 || last_idx !== 4'd9 || last_data !== 8'h5A) begin failures++; $display("FAIL rmr_wr: got cnt=%0d idx=%h data=%h expected 1/9/5a", wr_count - wc0, last_idx, last_data); end
      checks++; if (collide_rd !== 8'h00) begin failures++; $display("FAIL rd_collision_old: got %h expected 00", collide_rd); end
      checks++; if (rd_data !== 8'h5A) begin failures++; $display("FAIL rmr_readback: got %h expected 5a", rd_data); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_id();
      test_write_reg0();
      test_addr_nack();
      test_multi_byte();
      test_stop_mid_wdata();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h53, which is the 7-bit I2C target address it responds to.
REQ-002 The block SHALL have parameter DEV_ID, default 8'hE5, which is the read-only content of register 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port scl_in, input, 1 bit: the I2C SCL line, asynchronous to clk.
REQ-006 The block SHALL have port sda_in, input, 1 bit: the I2C SDA line, asynchronous to clk.
REQ-007 The block SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low; 0 releases SDA (open-drain).
REQ-008 The block SHALL have port busy, output, 1 bit: high from an address match until STOP.
REQ-009 The block SHALL have port wr_strobe, output, 1 bit: one-clk pulse on each register write.
REQ-010 The block SHALL have ports wr_index (output, 4 bits) and wr_data (output, 8 bits): the written register's index and value, valid with wr_strobe.
REQ-011 The block SHALL have ports rd_index (input, 4 bits) and rd_data (output, 8 bits): local register readback, with rd_data registered one clk after rd_index.

Function
REQ-012 SCL and SDA SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized values; clk SHALL be at least 8x the SCL frequency.
REQ-013 START SHALL be SDA falling while SCL is high; STOP SHALL be SDA rising while SCL is high.
REQ-014 SDA SHALL be sampled on SCL rising edges; sda_oe SHALL change only within 3 clk of an SCL falling edge.
REQ-015 The FSM SHALL have states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK.
REQ-016 START (including repeated START) from any state SHALL go to ADDR and clear the bit counter.
REQ-017 STOP in any state SHALL go to IDLE, release sda_oe and drop busy.
REQ-018 In ADDR, the block SHALL shift 8 bits MSB-first.
REQ-019 If bits[7:1] equal DEV_ADDR, the block SHALL drive ACK (sda_oe=1) for the 9th bit, assert busy, and go to ADDR_ACK.
REQ-020 On an address mismatch, the block SHALL NACK (sda_oe stays 0) and go to IDLE.
REQ-021 After ADDR_ACK with R/W=0, the next byte SHALL be the pointer; ptr SHALL be set to byte[3:0]; the byte SHALL be ACKed (PTR_ACK); the FSM SHALL then go to WDATA.
REQ-022 Each WDATA byte SHALL be ACKed.
REQ-023 For a WDATA byte to index 1..15, the block SHALL write reg[ptr] and pulse wr_strobe with wr_index=ptr and wr_data=byte at the 8th SCL rise plus 1 clk.
REQ-024 A WDATA byte to index 0 SHALL be ACKed but discarded, with no wr_strobe.
REQ-025 After ADDR_ACK with R/W=1, the block SHALL load reg[ptr] and drive its bits MSB-first (sda_oe = ~bit) in RDATA, then release SDA in RDATA_MACK.
REQ-026 In RDATA_MACK, master ACK (SDA=0) SHALL continue RDATA with the next byte; master NACK SHALL go to IDLE with sda_oe=0.
REQ-027 ptr SHALL be 4 bits and wrap 15->0.
REQ-028 ptr SHALL persist across transactions until rewritten or reset.
REQ-029 Reading register 0 SHALL always return DEV_ID.
REQ-030 When a local rd_index read and a wr_strobe to the same index occur in the same clk, rd_data SHALL return the old value.

Reset
REQ-031 While reset_n=0, all state SHALL be forced asynchronously: FSM=IDLE, sda_oe=0, busy=0, wr_strobe=0, wr_index=0, wr_data=0, rd_data=0, ptr=0, regs 1..15=8'h00, synchronizers=1.
REQ-032 Reset mid-transfer SHALL release SDA immediately; the block SHALL then ignore the bus until the next START.

Configuration
REQ-033 With I2C_TARGET_AUTOINC_EN defined, ptr SHALL increment after each WDATA byte and each RDATA byte (wrapping per REQ-027).
REQ-034 Without I2C_TARGET_AUTOINC_EN, ptr SHALL stay fixed for the whole transaction, so all data bytes access the same register.

Verification
REQ-035 START, 0xA6, 0x05, 0x3C, STOP -> ACK on all three bytes; wr_strobe once with wr_index=5, wr_data=0x3C; rd_index=5 -> rd_data=0x3C.
REQ-036 START, 0xA6, 0x00, repeated START, 0xA7, read one byte, master NACK, STOP -> returns 0xE5; sda_oe=0 after NACK.
REQ-037 START, 0xA8, STOP -> NACK on the address; busy stays 0; no wr_strobe.
REQ-038 With I2C_TARGET_AUTOINC_EN: write ptr=0x0F, data 0x11, 0x22 -> reg15=0x11; reg0 unchanged (0xE5); ptr=1 afterwards. Without it: reg15=0x22.
REQ-039 reset_n pulsed low during RDATA bit 3 -> sda_oe=0 within the same clk; a following full write transaction completes normally.
REQ-040 STOP issued mid-WDATA after 4 bits -> no wr_strobe; FSM=IDLE; busy=0.
